// File: rtl/decode_pkg.sv
// Shared defaults, field-offset helpers and the default decoded entry layout
// for the instruction decode stage.
package decode_pkg;

    localparam int DEF_ILEN   = 16;
    localparam int DEF_OPC_W  = 4;
    localparam int DEF_REG_W  = 3;
    localparam int DEF_IMM_W  = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_SEQ_W  = 8;

    // Fields are packed from the top of the word downwards: opcode, rD, flag, rA, rB.
    function automatic int rd_lsb(input int ilen, input int opc_w, input int reg_w);
        return ilen - opc_w - reg_w;
    endfunction

    function automatic int flag_bit(input int ilen, input int opc_w, input int reg_w);
        return rd_lsb(ilen, opc_w, reg_w) - 1;
    endfunction

    function automatic int ra_lsb(input int ilen, input int opc_w, input int reg_w);
        return flag_bit(ilen, opc_w, reg_w) - reg_w;
    endfunction

    function automatic int rb_lsb(input int ilen, input int opc_w, input int reg_w);
        return ra_lsb(ilen, opc_w, reg_w) - reg_w;
    endfunction

    localparam int DEF_RD_LSB   = rd_lsb(DEF_ILEN, DEF_OPC_W, DEF_REG_W);
    localparam int DEF_FLAG_BIT = flag_bit(DEF_ILEN, DEF_OPC_W, DEF_REG_W);
    localparam int DEF_RA_LSB   = ra_lsb(DEF_ILEN, DEF_OPC_W, DEF_REG_W);
    localparam int DEF_RB_LSB   = rb_lsb(DEF_ILEN, DEF_OPC_W, DEF_REG_W);

    typedef struct packed {
        logic [DEF_OPC_W-1:0]  opcode;
        logic [DEF_REG_W-1:0]  rd;
        logic                  flag;
        logic [DEF_REG_W-1:0]  ra;
        logic [DEF_REG_W-1:0]  rb;
        logic [DEF_DATA_W-1:0] imm;
        logic                  illegal;
        logic [DEF_SEQ_W-1:0]  seq;
    } decoded_t;

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready skid buffer: an output register plus one skid slot,
// giving full throughput while in_ready comes straight from a flop.
module decode_skid_buf
    import decode_pkg::*;
#(
    parameter type T = decoded_t
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    T     skid_data;
    logic skid_valid;
    logic accept;
    logic out_free;

    assign accept   = in_valid & in_ready & ~flush;
    assign out_free = ~out_valid | out_ready;

    // in_ready is just the registered "skid slot empty"; it can only accept
    // while the skid is empty, so a drain and an accept never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (out_free) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field split, immediate extension, legality check
// and sequence tagging, registered through a two-entry skid buffer.
module decode_stage
    import decode_pkg::*;
#(
    parameter int ILEN   = DEF_ILEN,
    parameter int OPC_W  = DEF_OPC_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEQ_W  = DEF_SEQ_W,
    parameter logic [(1<<OPC_W)-1:0] LEGAL_MASK = '1,
    parameter logic [(1<<OPC_W)-1:0] SEXT_MASK  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_flag,
    output logic [REG_W-1:0]  out_ra,
    output logic [REG_W-1:0]  out_rb,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_illegal,
    output logic [SEQ_W-1:0]  out_seq
);

    localparam int RD_LSB   = rd_lsb(ILEN, OPC_W, REG_W);
    localparam int FLAG_BIT = flag_bit(ILEN, OPC_W, REG_W);
    localparam int RA_LSB   = ra_lsb(ILEN, OPC_W, REG_W);
    localparam int RB_LSB   = rb_lsb(ILEN, OPC_W, REG_W);

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rd;
        logic              flag;
        logic [REG_W-1:0]  ra;
        logic [REG_W-1:0]  rb;
        logic [DATA_W-1:0] imm;
        logic              illegal;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    entry_t            dec;
    entry_t            out_entry;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] imm_ext;
    logic [SEQ_W-1:0]  seq_cnt;
    logic              accept;

    assign opcode = in_inst[ILEN-1 -: OPC_W];

    if (DATA_W > IMM_W) begin : g_ext
        logic fill;
        assign fill    = SEXT_MASK[opcode] & in_inst[IMM_W-1];
        assign imm_ext = {{(DATA_W-IMM_W){fill}}, in_inst[IMM_W-1:0]};
    end else begin : g_noext
        assign imm_ext = in_inst[IMM_W-1:0];
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = opcode;
        dec.rd      = in_inst[RD_LSB +: REG_W];
        dec.flag    = in_inst[FLAG_BIT];
        dec.ra      = in_inst[RA_LSB +: REG_W];
        dec.rb      = in_inst[RB_LSB +: REG_W];
        dec.imm     = imm_ext;
        dec.illegal = ~LEGAL_MASK[opcode];
        dec.seq     = seq_cnt;
    end

    // The tag advances only on a real accept, so flushed-away offers cost nothing.
    assign accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_cnt <= '0;
        end else if (accept) begin
            seq_cnt <= seq_cnt + 1'b1;
        end
    end

    decode_skid_buf #(.T(entry_t)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_opcode  = out_entry.opcode;
    assign out_rd      = out_entry.rd;
    assign out_flag    = out_entry.flag;
    assign out_ra      = out_entry.ra;
    assign out_rb      = out_entry.rb;
    assign out_imm     = out_entry.imm;
    assign out_illegal = out_entry.illegal;
    assign out_seq     = out_entry.seq;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by a
// randomized stream, scored against a queue-based reference model.
module tb_decode_stage;

    localparam int LEGAL_I = 'h7DFF;
    localparam int SEXT_I  = 'h0A08;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic        out_flag;
    logic [2:0]  out_ra;
    logic [2:0]  out_rb;
    logic [15:0] out_imm;
    logic        out_illegal;
    logic [7:0]  out_seq;

    decode_stage #(
        .ILEN(16), .OPC_W(4), .REG_W(3), .IMM_W(8), .DATA_W(16), .SEQ_W(8),
        .LEGAL_MASK(16'h7DFF), .SEXT_MASK(16'h0A08)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_flag    (out_flag),
        .out_ra      (out_ra),
        .out_rb      (out_rb),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .out_seq     (out_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int opcode;
        int rd;
        int flag;
        int ra;
        int rb;
        int imm;
        int illegal;
        int seq;
    } exp_t;

    exp_t q[$];
    int   model_seq;
    int   vectors;
    int   miscompares;

    function automatic exp_t ref_decode(input int inst, input int seq);
        exp_t e;
        int   raw;
        e.opcode  = inst / 4096;
        e.rd      = (inst / 512) % 8;
        e.flag    = (inst / 256) % 2;
        e.ra      = (inst / 32) % 8;
        e.rb      = (inst / 4) % 8;
        raw       = inst % 256;
        e.imm     = (((SEXT_I >> e.opcode) % 2) == 1 && raw >= 128) ? raw + 'hFF00 : raw;
        e.illegal = ((LEGAL_I >> e.opcode) % 2 == 0) ? 1 : 0;
        e.seq     = seq;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        chk("in_ready", {31'd0, in_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
        if (q.size() > 0) begin
            chk("opcode", {28'd0, out_opcode}, q[0].opcode);
            chk("rd", {29'd0, out_rd}, q[0].rd);
            chk("flag", {31'd0, out_flag}, q[0].flag);
            chk("ra", {29'd0, out_ra}, q[0].ra);
            chk("rb", {29'd0, out_rb}, q[0].rb);
            chk("imm", {16'd0, out_imm}, q[0].imm);
            chk("illegal", {31'd0, out_illegal}, q[0].illegal);
            chk("seq", {24'd0, out_seq}, q[0].seq);
        end
    endtask

    // Drive one cycle's inputs, check the currently registered outputs, then
    // advance the model by what the handshakes should do at the coming edge.
    task automatic applyStimulus(input logic v, input logic [15:0] inst,
                                 input logic rdy, input logic fl);
        logic acc;
        logic fire;
        in_valid  = v;
        in_inst   = inst;
        out_ready = rdy;
        flush     = fl;
        checkOutput();
        acc  = v && (q.size() < 2) && !fl;
        fire = (q.size() > 0) && rdy && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (fire) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_decode(int'(inst), model_seq));
                model_seq = (model_seq + 1) % 256;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_opcode"}, {28'd0, out_opcode}, 32'd0);
        chk({tag, "_imm"}, {16'd0, out_imm}, 32'd0);
        chk({tag, "_illegal"}, {31'd0, out_illegal}, 32'd0);
        chk({tag, "_seq"}, {24'd0, out_seq}, 32'd0);
    endtask

    initial begin
        logic [15:0] stream [4];
        logic [15:0] last_tag;
        int          idx;
        vectors     = 0;
        miscompares = 0;
        model_seq   = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_inst     = '0;
        out_ready   = 1'b0;
        #12;
        checkResetState("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Opcode 3 sign-extends here, so 3A85 widens with ones and 3A05 with zeros.
        applyStimulus(1'b1, 16'h3A85, 1'b1, 1'b0);
        chk("first_opcode", {28'd0, out_opcode}, 32'd3);
        chk("first_rd", {29'd0, out_rd}, 32'd5);
        chk("first_ra", {29'd0, out_ra}, 32'd4);
        chk("first_rb", {29'd0, out_rb}, 32'd1);
        chk("first_imm", {16'd0, out_imm}, 32'hFF85);
        chk("first_seq", {24'd0, out_seq}, 32'd0);
        applyStimulus(1'b1, 16'h3A05, 1'b1, 1'b0);
        chk("sext_pos_imm", {16'd0, out_imm}, 32'h0005);
        applyStimulus(1'b1, 16'h2A85, 1'b1, 1'b0);
        chk("zext_imm", {16'd0, out_imm}, 32'h0085);
        applyStimulus(1'b1, 16'hF000, 1'b1, 1'b0);
        chk("illegal_flag", {31'd0, out_illegal}, 32'd1);
        chk("illegal_valid", {31'd0, out_valid}, 32'd1);
        chk("illegal_seq", {24'd0, out_seq}, 32'd3);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Four-word stream with the consumer stalled for three cycles.
        stream[0] = 16'h1234;
        stream[1] = 16'h5A5A;
        stream[2] = 16'h9F81;
        stream[3] = 16'hB7C3;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            logic v;
            logic rdy;
            v   = (idx < 4);
            rdy = !(c >= 1 && c <= 3);
            if (v && q.size() < 2) begin
                applyStimulus(1'b1, stream[idx], rdy, 1'b0);
                idx++;
            end else begin
                applyStimulus(v, (idx < 4) ? stream[idx] : 16'h0000, rdy, 1'b0);
            end
        end
        chk("stream_all_accepted", idx, 32'd4);

        // Fill both entries, then flush while a new word is offered.
        applyStimulus(1'b1, 16'h4111, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h4222, 1'b0, 1'b0);
        last_tag = 16'(model_seq);
        applyStimulus(1'b1, 16'h4333, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0);
        chk("post_flush_seq", {24'd0, out_seq}, {16'd0, last_tag});

        // Randomized stream long enough to wrap the 8-bit tag several times.
        for (int c = 0; c < 1500; c++) begin
            applyStimulus(($urandom % 4) != 0, 16'($urandom), ($urandom % 4) != 0,
                          ($urandom % 40) == 0);
        end

        // Asynchronous reset in the middle of a stall discards everything.
        applyStimulus(1'b1, 16'h6A81, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h7B92, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h8CA3, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkResetState("midreset");
        reset     = 1'b0;
        in_valid  = 1'b0;
        q.delete();
        model_seq = 0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 16'h3A85, 1'b1, 1'b0);
        chk("after_reset_seq", {24'd0, out_seq}, 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
